// File: rtl/capture_sequencer_pkg.sv
// Shared types and defaults for the ADC capture sequencer.
package capture_sequencer_pkg;

    typedef enum logic [2:0] {
        StIdle     = 3'd0,
        StWaitIdle = 3'd1,
        StArmed    = 3'd2,
        StOffset   = 3'd3,
        StCapture  = 3'd4,
        StDone     = 3'd5
    } state_e;

    localparam int unsigned DataWDefault      = 10;
    localparam int unsigned CntWDefault       = 32;
    localparam int unsigned MaxSamplesDefault = 32'h0010_0000;

endpackage

// File: rtl/capture_sequencer_counter.sv
// Loadable down-counter with zero flag; holds at zero rather than wrapping.
module capture_sequencer_counter #(
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             load_i,
    input  logic [CNT_W-1:0] load_val_i,
    input  logic             dec_i,
    output logic             zero_o
);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/capture_sequencer.sv
// Sequences one ADC capture: arm, optional wait-for-inactive, trigger, offset skip,
// store a bounded number of samples into the FIFO, then report done.
module capture_sequencer
    import capture_sequencer_pkg::*;
#(
    parameter int unsigned DATA_W      = DataWDefault,
    parameter int unsigned CNT_W       = CntWDefault,
    parameter int unsigned MAX_SAMPLES = MaxSamplesDefault
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              arm_i,
    input  logic              trigger_mode_i,
    input  logic              trigger_wait_i,
    input  logic              trig_i,
    input  logic              trigger_now_i,
    input  logic [CNT_W-1:0]  offset_i,
    input  logic [CNT_W-1:0]  maxsamples_i,
    input  logic [DATA_W-1:0] adc_data_i,
    input  logic              fifo_full_i,
    output logic              fifo_wr_en_o,
    output logic [DATA_W-1:0] fifo_data_o,
    output logic              armed_o,
    output logic              capture_go_o,
    output logic              capture_done_o,
    output logic              overflow_o,
    output logic [CNT_W-1:0]  samples_o
);

    localparam logic [CNT_W-1:0] MaxCnt = CNT_W'(MAX_SAMPLES);

    state_e            state_q, state_d;
    logic              arm_q;
    logic              mode_q, mode_d;
    logic [CNT_W-1:0]  offset_q, offset_d;
    logic              wr_en_q, wr_en_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              armed_q, armed_d;
    logic              go_q, go_d;
    logic              done_q, done_d;
    logic              overflow_q, overflow_d;
    logic [CNT_W-1:0]  samples_q, samples_d;

    logic             arm_rise, trig_act, start;
    logic [CNT_W-1:0] limit;
    logic             off_load, off_dec, off_zero;
    logic             rem_load, rem_dec, rem_zero;

    assign arm_rise = arm_i & ~arm_q;
    assign trig_act = (trig_i == mode_q) | trigger_now_i;
    assign limit    = ((maxsamples_i == '0) || (maxsamples_i > MaxCnt)) ? MaxCnt : maxsamples_i;

    always_comb begin
        state_d    = state_q;
        mode_d     = mode_q;
        offset_d   = offset_q;
        wr_en_d    = 1'b0;
        data_d     = data_q;
        done_d     = 1'b0;
        overflow_d = overflow_q;
        samples_d  = samples_q;
        start      = 1'b0;
        off_load   = 1'b0;
        off_dec    = 1'b0;
        rem_load   = 1'b0;
        rem_dec    = 1'b0;

        case (state_q)
            StIdle: begin
                if (arm_rise) begin
                    samples_d  = '0;
                    overflow_d = 1'b0;
                    mode_d     = trigger_mode_i;
                    offset_d   = offset_i;
                    rem_load   = 1'b1;
                    state_d    = trigger_wait_i ? StWaitIdle : StArmed;
                end
            end
            StWaitIdle: begin
                if (!arm_i) begin
                    state_d = StIdle;
                end else if (trigger_now_i) begin
                    start = 1'b1;
                end else if (trig_i != mode_q) begin
                    state_d = StArmed;
                end
            end
            StArmed: begin
                if (!arm_i) begin
                    state_d = StIdle;
                end else if (trig_act) begin
                    start = 1'b1;
                end
            end
            StOffset: begin
                if (off_zero) begin
                    state_d = StCapture;
                end else begin
                    off_dec = 1'b1;
                end
            end
            StCapture: begin
                if (fifo_full_i) begin
                    overflow_d = 1'b1;
                    done_d     = 1'b1;
                    state_d    = StDone;
                end else begin
                    wr_en_d   = 1'b1;
                    data_d    = adc_data_i;
                    samples_d = samples_q + CNT_W'(1);
                    // Remaining counter holds limit-1, so zero marks the final sample.
                    if (rem_zero) begin
                        done_d  = 1'b1;
                        state_d = StDone;
                    end else begin
                        rem_dec = 1'b1;
                    end
                end
            end
            StDone: begin
                if (!arm_i) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        if (start) begin
            if (offset_q != '0) begin
                off_load = 1'b1;
                state_d  = StOffset;
            end else begin
                state_d = StCapture;
            end
        end

        armed_d = (state_d == StWaitIdle) || (state_d == StArmed);
        go_d    = (state_d == StOffset) || (state_d == StCapture);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= StIdle;
            arm_q      <= 1'b0;
            mode_q     <= 1'b0;
            offset_q   <= '0;
            wr_en_q    <= 1'b0;
            data_q     <= '0;
            armed_q    <= 1'b0;
            go_q       <= 1'b0;
            done_q     <= 1'b0;
            overflow_q <= 1'b0;
            samples_q  <= '0;
        end else begin
            state_q    <= state_d;
            arm_q      <= arm_i;
            mode_q     <= mode_d;
            offset_q   <= offset_d;
            wr_en_q    <= wr_en_d;
            data_q     <= data_d;
            armed_q    <= armed_d;
            go_q       <= go_d;
            done_q     <= done_d;
            overflow_q <= overflow_d;
            samples_q  <= samples_d;
        end
    end

    capture_sequencer_counter #(
        .CNT_W (CNT_W)
    ) u_offset_cnt (
        .clk_i      (clk),
        .reset_i    (reset),
        .load_i     (off_load),
        .load_val_i (offset_q - CNT_W'(1)),
        .dec_i      (off_dec),
        .zero_o     (off_zero)
    );

    capture_sequencer_counter #(
        .CNT_W (CNT_W)
    ) u_remain_cnt (
        .clk_i      (clk),
        .reset_i    (reset),
        .load_i     (rem_load),
        .load_val_i (limit - CNT_W'(1)),
        .dec_i      (rem_dec),
        .zero_o     (rem_zero)
    );

    assign fifo_wr_en_o   = wr_en_q;
    assign fifo_data_o    = data_q;
    assign armed_o        = armed_q;
    assign capture_go_o   = go_q;
    assign capture_done_o = done_q;
    assign overflow_o     = overflow_q;
    assign samples_o      = samples_q;

endmodule

// File: tb/tb_capture_sequencer.sv
// Directed bench for capture_sequencer; small MAX_SAMPLES keeps the default-count run short.
module tb_capture_sequencer;

    localparam int unsigned DW = 10;
    localparam int unsigned CW = 32;
    localparam int unsigned MS = 200;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          arm_i = 1'b0;
    logic          trigger_mode_i = 1'b1;
    logic          trigger_wait_i = 1'b0;
    logic          trig_i = 1'b0;
    logic          trigger_now_i = 1'b0;
    logic [CW-1:0] offset_i = '0;
    logic [CW-1:0] maxsamples_i = '0;
    logic [DW-1:0] adc_data_i;
    logic          fifo_full_i = 1'b0;
    logic          fifo_wr_en_o;
    logic [DW-1:0] fifo_data_o;
    logic          armed_o;
    logic          capture_go_o;
    logic          capture_done_o;
    logic          overflow_o;
    logic [CW-1:0] samples_o;

    capture_sequencer #(
        .DATA_W      (DW),
        .CNT_W       (CW),
        .MAX_SAMPLES (MS)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .arm_i          (arm_i),
        .trigger_mode_i (trigger_mode_i),
        .trigger_wait_i (trigger_wait_i),
        .trig_i         (trig_i),
        .trigger_now_i  (trigger_now_i),
        .offset_i       (offset_i),
        .maxsamples_i   (maxsamples_i),
        .adc_data_i     (adc_data_i),
        .fifo_full_i    (fifo_full_i),
        .fifo_wr_en_o   (fifo_wr_en_o),
        .fifo_data_o    (fifo_data_o),
        .armed_o        (armed_o),
        .capture_go_o   (capture_go_o),
        .capture_done_o (capture_done_o),
        .overflow_o     (overflow_o),
        .samples_o      (samples_o)
    );

    always #5 clk = ~clk;

    // ADC ramp: each sample equals the number of rising edges seen so far.
    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;
    assign adc_data_i = DW'(cyc);

    int unsigned wr_data[$];
    int unsigned wr_cyc[$];
    int unsigned done_cnt = 0;

    always @(negedge clk) begin
        if (fifo_wr_en_o) begin
            wr_data.push_back(int'(fifo_data_o));
            wr_cyc.push_back(cyc);
        end
        if (capture_done_o) done_cnt++;
    end

    int checks = 0;
    int errors = 0;

    task automatic check_eq(input string tag, input longint unsigned got,
                            input longint unsigned exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step(input int n = 1);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic clear_log();
        wr_data.delete();
        wr_cyc.delete();
        done_cnt = 0;
    endtask

    task automatic wait_done(input string tag, input int budget);
        int i = 0;
        while (done_cnt == 0 && i < budget) begin
            step();
            i++;
        end
        check_eq(tag, longint'(done_cnt != 0), 1);
    endtask

    function automatic int unsigned q_at(input int unsigned q[$], input int idx);
        if (idx < 0 || idx >= q.size()) return 32'hFFFF_FFFF;
        return q[idx];
    endfunction

    int unsigned t0;

    initial begin
        // Reset state
        step(3);
        check_eq("rst_wr_en", fifo_wr_en_o, 0);
        check_eq("rst_armed", armed_o, 0);
        check_eq("rst_go", capture_go_o, 0);
        check_eq("rst_done", capture_done_o, 0);
        check_eq("rst_ovf", overflow_o, 0);
        check_eq("rst_samples", samples_o, 0);
        reset = 1'b0;
        step();

        // 1: active-high trigger, no offset, 8 samples
        trigger_mode_i = 1'b1;
        maxsamples_i = 8;
        arm_i = 1'b1;
        step();
        check_eq("t1_armed", armed_o, 1);
        clear_log();
        trig_i = 1'b1;
        t0 = cyc;
        step();
        trig_i = 1'b0;
        wait_done("t1_done_seen", 40);
        check_eq("t1_done_cyc", cyc, t0 + 9);
        step(3);
        check_eq("t1_nwr", wr_data.size(), 8);
        check_eq("t1_first_cyc", q_at(wr_cyc, 0), t0 + 2);
        check_eq("t1_last_cyc", q_at(wr_cyc, 7), t0 + 9);
        check_eq("t1_first_data", q_at(wr_data, 0), (t0 + 1) % 1024);
        check_eq("t1_samples", samples_o, 8);
        check_eq("t1_ndone", done_cnt, 1);
        check_eq("t1_armed_after", armed_o, 0);
        check_eq("t1_go_after", capture_go_o, 0);
        arm_i = 1'b0;
        step(2);

        // 2: offset 5, 4 samples; input changes after arming must be ignored
        offset_i = 5;
        maxsamples_i = 4;
        arm_i = 1'b1;
        step();
        offset_i = 0;
        maxsamples_i = 50;
        step();
        clear_log();
        trig_i = 1'b1;
        t0 = cyc;
        step();
        trig_i = 1'b0;
        step(3);
        check_eq("t2_go_in_offset", capture_go_o, 1);
        check_eq("t2_no_wr_in_offset", wr_data.size(), 0);
        wait_done("t2_done_seen", 60);
        step(2);
        check_eq("t2_nwr", wr_data.size(), 4);
        check_eq("t2_first_cyc", q_at(wr_cyc, 0), t0 + 7);
        check_eq("t2_first_data", q_at(wr_data, 0), (t0 + 6) % 1024);
        check_eq("t2_last_data", q_at(wr_data, 3), (t0 + 9) % 1024);
        arm_i = 1'b0;
        step(2);

        // 3: wait-for-inactive with active-low trigger already active at arm
        trigger_mode_i = 1'b0;
        trigger_wait_i = 1'b1;
        trig_i = 1'b0;
        maxsamples_i = 3;
        clear_log();
        arm_i = 1'b1;
        step(4);
        check_eq("t3_armed_wait", armed_o, 1);
        check_eq("t3_go_wait", capture_go_o, 0);
        check_eq("t3_nwr_wait", wr_data.size(), 0);
        trig_i = 1'b1;
        step(2);
        check_eq("t3_armed", armed_o, 1);
        check_eq("t3_go_armed", capture_go_o, 0);
        trig_i = 1'b0;
        t0 = cyc;
        step();
        wait_done("t3_done_seen", 20);
        step(2);
        check_eq("t3_nwr", wr_data.size(), 3);
        check_eq("t3_first_cyc", q_at(wr_cyc, 0), t0 + 2);
        arm_i = 1'b0;
        step(2);
        trigger_mode_i = 1'b1;
        trigger_wait_i = 1'b0;

        // 4: FIFO full after 40 writes, then re-arm clears overflow
        maxsamples_i = 100;
        arm_i = 1'b1;
        step();
        clear_log();
        trig_i = 1'b1;
        step();
        trig_i = 1'b0;
        for (int i = 0; i < 200 && wr_data.size() < 40; i++) step();
        fifo_full_i = 1'b1;
        wait_done("t4_done_seen", 10);
        step(2);
        fifo_full_i = 1'b0;
        check_eq("t4_nwr", wr_data.size(), 40);
        check_eq("t4_ovf", overflow_o, 1);
        check_eq("t4_ndone", done_cnt, 1);
        check_eq("t4_samples", samples_o, 40);
        arm_i = 1'b0;
        step(2);
        arm_i = 1'b1;
        step();
        check_eq("t4_rearm_ovf", overflow_o, 0);
        check_eq("t4_rearm_samples", samples_o, 0);
        check_eq("t4_rearm_armed", armed_o, 1);

        // 5: disarm before trigger, trigger in IDLE, then forced trigger
        clear_log();
        arm_i = 1'b0;
        step(2);
        check_eq("t5_disarm_armed", armed_o, 0);
        trig_i = 1'b1;
        step(3);
        trig_i = 1'b0;
        check_eq("t5_idle_go", capture_go_o, 0);
        check_eq("t5_idle_nwr", wr_data.size(), 0);
        check_eq("t5_idle_ndone", done_cnt, 0);
        maxsamples_i = 2;
        arm_i = 1'b1;
        step();
        clear_log();
        trigger_now_i = 1'b1;
        trig_i = 1'b1;
        t0 = cyc;
        step();
        trigger_now_i = 1'b0;
        trig_i = 1'b0;
        wait_done("t5_done_seen", 20);
        step(2);
        check_eq("t5_nwr", wr_data.size(), 2);
        check_eq("t5_first_cyc", q_at(wr_cyc, 0), t0 + 2);
        check_eq("t5_ndone", done_cnt, 1);
        arm_i = 1'b0;
        step(2);

        // 6: reset mid-capture, then default and clamped sample counts
        maxsamples_i = 50;
        arm_i = 1'b1;
        step();
        trig_i = 1'b1;
        step();
        trig_i = 1'b0;
        step(5);
        check_eq("t6_go_before_rst", capture_go_o, 1);
        reset = 1'b1;
        arm_i = 1'b0;
        step();
        check_eq("t6_rst_wr_en", fifo_wr_en_o, 0);
        check_eq("t6_rst_go", capture_go_o, 0);
        check_eq("t6_rst_armed", armed_o, 0);
        check_eq("t6_rst_samples", samples_o, 0);
        check_eq("t6_rst_done", capture_done_o, 0);
        reset = 1'b0;
        step();
        clear_log();
        maxsamples_i = 0;
        arm_i = 1'b1;
        step();
        trig_i = 1'b1;
        step();
        trig_i = 1'b0;
        wait_done("t6_def_done_seen", 300);
        step(2);
        check_eq("t6_def_nwr", wr_data.size(), MS);
        check_eq("t6_def_samples", samples_o, MS);
        arm_i = 1'b0;
        step(2);
        clear_log();
        maxsamples_i = 500;
        arm_i = 1'b1;
        step();
        trig_i = 1'b1;
        step();
        trig_i = 1'b0;
        wait_done("t6_clamp_done_seen", 300);
        step(2);
        check_eq("t6_clamp_nwr", wr_data.size(), MS);
        arm_i = 1'b0;
        step(2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
